ir_ea_sequencer: RTL

Registered PDP-8 instruction decoder with an effective-address (EA) sequencer; successor to the combinational IR decoder.
- Takes an instruction and the PC it was fetched from.
- Decodes the opcode and forms the direct address.
- Performs the indirect fetch and auto-index increment/write-back through a req/ack memory port.
- Presents a stable EA and decode set to the major-state controller.
- Word and page-offset widths are parametrised.

---
 rtl/ir_ea_pkg.sv | 48 ++++
 rtl/ir_ea_sequencer_if.sv | 23 ++
 rtl/ir_field_decode.sv | 36 +++
 rtl/ir_ea_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ir_ea_pkg.sv
// ir_ea_pkg: shared definitions for the PDP-8 IR decoder / EA sequencer.
//   - opcode constants OP_AND..OP_OPR (IR top three bits)
//   - sequencer state enum (S_AI_WR exists only with IR_AUTOINDEX_EN)
//   - IR field positions for the default geometry, plus helper functions
//     that derive the same positions for any WORD_W/OFS_W
// Optional feature macro: IR_AUTOINDEX_EN
package ir_ea_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    localparam int DEF_WORD_W = 12;
    localparam int DEF_OFS_W  = 7;

    // IR[OFS_W] selects current page, IR[OFS_W+1] marks indirect
    function automatic int ind_bit(input int ofs_w);
        return ofs_w + 1;
    endfunction

    function automatic int mp_bit(input int ofs_w);
        return ofs_w;
    endfunction

    function automatic int opc_lsb(input int word_w);
        return word_w - 3;
    endfunction

    localparam int IND_BIT = ind_bit(DEF_OFS_W);
    localparam int MP_BIT  = mp_bit(DEF_OFS_W);
    localparam int OPC_LSB = opc_lsb(DEF_WORD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_IND_RD,
`ifdef IR_AUTOINDEX_EN
        S_AI_WR,
`endif
        S_FIN
    } state_t;

endpackage

// File: rtl/ir_ea_sequencer_if.sv
// ir_ea_sequencer_if: req/ack memory port used for the indirect fetch and
// the auto-index write-back.
//   req    master->slave  request, held until ack
//   we     master->slave  write qualifier for req
//   addr   master->slave  word address
//   wdata  master->slave  write data
//   rdata  slave->master  read data, valid with ack
//   ack    slave->master  single-cycle completion
interface ir_ea_sequencer_if
    import ir_ea_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/ir_field_decode.sv
// ir_field_decode: purely combinational split of a PDP-8 instruction word.
//   ir      in   instruction word
//   op      out  one-hot opcode, bit n set for opcode n (AND..OPR)
//   is_mri  out  memory-reference instruction (opcode < IOT)
//   ind     out  indirect bit, only meaningful for MRIs
//   mp      out  current-page bit
//   ofs     out  page offset
module ir_field_decode
    import ir_ea_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int OFS_W  = DEF_OFS_W
) (
    input  logic [WORD_W-1:0] ir,
    output logic [7:0]        op,
    output logic              is_mri,
    output logic              ind,
    output logic              mp,
    output logic [OFS_W-1:0]  ofs
);
    localparam int OPC_POS = opc_lsb(WORD_W);
    localparam int IND_POS = ind_bit(OFS_W);
    localparam int MP_POS  = mp_bit(OFS_W);

    logic [2:0] opcode;

    always_comb begin
        opcode = ir[OPC_POS +: 3];
        op     = 8'd1 << opcode;
        is_mri = (opcode < OP_IOT);
        // IOT/OPR reuse bit IND_POS as part of their own encoding
        ind    = is_mri & ir[IND_POS];
        mp     = ir[MP_POS];
        ofs    = ir[OFS_W-1:0];
    end
endmodule

// File: rtl/ir_ea_sequencer.sv
// ir_ea_sequencer: registered PDP-8 instruction decoder and effective-address
// sequencer. Latches IR/PC on start, decodes, performs the indirect fetch
// (and, with IR_AUTOINDEX_EN, the auto-index increment and write-back) over
// the memory port, then pulses done with a stable EA and decode set.
//   clk, resetn   clock, asynchronous active-low reset
//   start         IR/PC valid, accepted only while idle
//   ir, pc        instruction and the address it was fetched from
//   busy, done    sequencer status; done is a one-cycle pulse
//   ea            effective address
//   op            one-hot opcode (AND..OPR = bit 0..7)
//   is_mri, ind   memory-reference / indirect flags
//   autoidx       indirect went through an auto-index location
//   mem           memory master port (req/we/addr/wdata/rdata/ack)
// Optional feature macro: IR_AUTOINDEX_EN (undefined: no auto-index,
// indirect through the auto-index window is a plain indirect).
module ir_ea_sequencer
    import ir_ea_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int OFS_W    = DEF_OFS_W,
    parameter int AI_BASE  = 8,
    parameter int AI_COUNT = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [WORD_W-1:0]   ir,
    input  logic [WORD_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output logic [WORD_W-1:0]   ea,
    output logic [7:0]          op,
    output logic                is_mri,
    output logic                ind,
    output logic                autoidx,
    ir_ea_sequencer_if.master   mem
);
    localparam logic [WORD_W-1:0] OFS_MASK = WORD_W'((1 << OFS_W) - 1);
    localparam logic [WORD_W-1:0] AI_LO    = WORD_W'(AI_BASE);
    localparam logic [WORD_W-1:0] AI_HI    = WORD_W'(AI_BASE + AI_COUNT);
`ifdef IR_AUTOINDEX_EN
    localparam bit AI_EN = 1'b1;
`else
    localparam bit AI_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] ir_q;
    logic [WORD_W-1:0] pc_q;
    logic [7:0]        dec_op;
    logic              dec_is_mri;
    logic              dec_ind;
    logic              dec_mp;
    logic [OFS_W-1:0]  dec_ofs;
    logic [WORD_W-1:0] da;
    logic              ai_hit;

    ir_field_decode #(
        .WORD_W (WORD_W),
        .OFS_W  (OFS_W)
    ) u_decode (
        .ir     (ir_q),
        .op     (dec_op),
        .is_mri (dec_is_mri),
        .ind    (dec_ind),
        .mp     (dec_mp),
        .ofs    (dec_ofs)
    );

    // Direct address: page bits come from PC only for current-page refs.
    // ir_q/pc_q are frozen while busy, so da is stable for the memory port.
    always_comb begin
        da = {{(WORD_W-OFS_W){1'b0}}, dec_ofs};
        if (dec_mp) begin
            da = da | (pc_q & ~OFS_MASK);
        end
        ai_hit = AI_EN && (da >= AI_LO) && (da < AI_HI);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory port outputs are decoded from state so an asynchronous reset
    // drops req immediately, even mid-transaction.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem.req   = 1'b0;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = dec_ind ? S_IND_RD : S_FIN;
            end
            S_IND_RD: begin
                mem.req  = 1'b1;
                mem.addr = da;
                if (mem.ack) begin
`ifdef IR_AUTOINDEX_EN
                    state_nxt = ai_hit ? S_AI_WR : S_FIN;
`else
                    state_nxt = S_FIN;
`endif
                end
            end
`ifdef IR_AUTOINDEX_EN
            S_AI_WR: begin
                mem.req   = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = da;
                mem.wdata = ea;
                if (mem.ack) begin
                    state_nxt = S_FIN;
                end
            end
`endif
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Decode outputs are held from one decode until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ir_q   <= '0;
            pc_q   <= '0;
            ea     <= '0;
            op     <= '0;
            is_mri <= 1'b0;
            ind    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ir_q <= ir;
                        pc_q <= pc;
                    end
                end
                S_DECODE: begin
                    op     <= dec_op;
                    is_mri <= dec_is_mri;
                    ind    <= dec_ind;
                    if (!dec_is_mri) begin
                        ea <= '0;
                    end else if (!dec_ind) begin
                        ea <= da;
                    end
                end
                S_IND_RD: begin
                    // the pointer increment wraps naturally at the word width
                    if (mem.ack) begin
                        ea <= mem.rdata + {{(WORD_W-1){1'b0}}, ai_hit};
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IR_AUTOINDEX_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            autoidx <= 1'b0;
        end else if (state == S_IDLE && start) begin
            autoidx <= 1'b0;
        end else if (state == S_IND_RD && mem.ack && ai_hit) begin
            autoidx <= 1'b1;
        end
    end
`else
    assign autoidx = 1'b0;
`endif

endmodule
